fram_frame_sequencer: RTL
=========================

// Module: fram_frame_sequencer
// PURPOSE
// - Single-clock controller for the on-chip frame RAM and its write/read address counters.
// - Sequences one capture into the buffer per accepted sensor frame, then streams that frame to the display side.
// - Drives W_CLR/W_DE/R_CLR/R_DE; the RAM and counters are instantiated beside it.
// - Guarantees no tearing: the buffer is never written while it is being read. Sensor frames arriving during a read are dropped and counted.
// PARAMETERS
// - FRAME_PIXELS  307200  pixels per frame (640x480); write and read both stop at this count.
// - CNT_W         20      width of internal pixel counters; must satisfy 2**CNT_W > FRAME_PIXELS.
// - RD_LAT        1       RAM read latency in clocks; delay from R_DE to R_VALID.
// PORTS
// - CLOCK       in   1      sole clock; sensor, RAM and display all run on it.
// - RESET       in   1      asynchronous, active-high reset.
// - IN_FVAL     in   1      sensor frame valid, level; a rising edge marks start of frame.
// - IN_DVAL     in   1      sensor pixel valid, qualified by IN_FVAL.
// - OUT_VS      in   1      display vsync, 1-cycle pulse marking start of display frame.
// - OUT_REQ     in   1      display pixel request.
// - W_CLR       out  1      1-cycle write-counter clear.
// - W_DE        out  1      RAM write enable / write-counter advance.
// - R_CLR       out  1      1-cycle read-counter clear.
// - R_DE        out  1      read-counter advance.
// - R_VALID     out  1      R_DE delayed RD_LAT clocks; RAM data is valid.
// - FRAME_READY out  1      buffer holds one complete frame.
// - ERR_SHORT   out  1      sticky: a capture ended before FRAME_PIXELS pixels.
// - DROP_CNT    out  8      number of sensor frames dropped; saturates at 255.
// BEHAVIOUR
// - Reset values: all outputs 0; both FSMs idle; counters 0.
// - fval_rise is a registered edge detect of IN_FVAL.
// - Write FSM states:
//   - W_IDLE: on fval_rise, go to W_CAPTURE if r_state!=R_STREAM. Otherwise stay, and DROP_CNT++ (saturating).
//   - W_CAPTURE: entered with W_CLR=1 for that 1 cycle, wcnt=0, and FRAME_READY forced to 0.
//   - W_CAPTURE: W_DE = IN_DVAL & IN_FVAL & (wcnt<FRAME_PIXELS). This is combinational, zero latency. wcnt++ on each W_DE.
//   - W_CAPTURE exits on IN_FVAL low. If wcnt==FRAME_PIXELS, set FRAME_READY=1; otherwise set ERR_SHORT=1 and leave FRAME_READY at 0. Then go to W_IDLE.
//   - Pixels beyond FRAME_PIXELS are ignored; this is not an error.
// - Read FSM states:
//   - R_IDLE: on OUT_VS with FRAME_READY=1 and w_state!=W_CAPTURE, go to R_STREAM with R_CLR=1 for 1 cycle and rcnt=0.
//   - R_IDLE: otherwise OUT_VS is ignored; display shows blank (R_VALID stays 0).
//   - R_STREAM: R_DE = OUT_REQ & (rcnt<FRAME_PIXELS). This is combinational. rcnt++ on each R_DE.
//   - R_STREAM: when rcnt reaches FRAME_PIXELS, go to R_IDLE. FRAME_READY stays 1, so the same frame is re-shown on the next OUT_VS.
//   - OUT_VS arriving inside R_STREAM restarts the stream: R_CLR pulses and rcnt=0.
// - Simultaneous events:
//   - fval_rise and OUT_VS in the same cycle, buffer ready: read wins, and the sensor frame is dropped.
//   - This keeps the read/write exclusion invariant: never W_DE=1 and R_DE=1 in the same cycle.
//   - W_CLR and R_CLR are never both 1.
// - Reset mid-frame: both FSMs return to idle and FRAME_READY=0. Any partial capture is discarded. The next capture starts only on a fresh fval_rise.
// - If IN_FVAL is already high when RESET deasserts, that is not treated as a rising edge.
// STRUCTURE
// - Shared package fram_pkg holds:
//   - state enums w_state_t {W_IDLE,W_CAPTURE} and r_state_t {R_IDLE,R_STREAM};
//   - FRAME_PIXELS_DEF and CNT_W_DEF constants.
// - One sub-module, fram_edge_pulse: registered rising-edge detector, used for IN_FVAL.
// - The RD_LAT delay line is an inline shift register.
// TESTING
// - Reset release with IN_FVAL=1 -> no capture; first W_CLR only after IN_FVAL falls and rises again.
// - FRAME_PIXELS=16 full frame, 20 DVAL pulses -> exactly 16 W_DE; FRAME_READY=1 one cycle after IN_FVAL falls; ERR_SHORT=0.
// - Short frame, 10 pixels -> FRAME_READY=0, ERR_SHORT=1; a later OUT_VS produces no R_CLR.
// - Ready frame, OUT_VS then 16 REQ -> R_CLR once, 16 R_DE, R_VALID lagging by RD_LAT; fval_rise mid-stream -> DROP_CNT=1 and no W_DE.
// - fval_rise and OUT_VS in the same cycle -> R_CLR=1, W_CLR=0, DROP_CNT+1; 300 drops -> DROP_CNT=255.
// - RESET asserted mid-capture -> outputs 0 asynchronously, FRAME_READY=0; the next full frame is captured correctly.

Source files
------------

// File: rtl/fram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fram_pkg: shared states and defaults for the frame RAM sequencer    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package fram_pkg;

  localparam int FRAME_PIXELS_DEF = 307200;
  localparam int CNT_W_DEF        = 20;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_CAPTURE = 1'b1} w_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_STREAM  = 1'b1} r_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fram_edge_pulse.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fram_edge_pulse: rising-edge detector against a registered sample   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fram_edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic prev_q, prev_d;

  always_comb begin
    prev_d = i_level;
  end

  // Resetting the history to 1 means a level already high at reset
  // release is never reported as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= prev_d;
  end

  assign o_rise = i_level & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/fram_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fram_frame_sequencer: single-buffer capture/stream control with     |
// | tear-free read/write exclusion. Rev 1.0                             |
// +--------------------------------------------------------------------+
module fram_frame_sequencer
  import fram_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int RD_LAT       = 1
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       IN_FVAL,
  input  logic       IN_DVAL,
  input  logic       OUT_VS,
  input  logic       OUT_REQ,
  output logic       W_CLR,
  output logic       W_DE,
  output logic       R_CLR,
  output logic       R_DE,
  output logic       R_VALID,
  output logic       FRAME_READY,
  output logic       ERR_SHORT,
  output logic [7:0] DROP_CNT
);

  localparam logic [CNT_W-1:0] FP_CNT  = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] FP_LAST = CNT_W'(FRAME_PIXELS - 1);

  logic fval_rise;

  fram_edge_pulse u_fval_edge (
    .clk     (CLOCK),
    .rst     (RESET),
    .i_level (IN_FVAL),
    .o_rise  (fval_rise)
  );

  w_state_t          w_state_q, w_state_d;
  r_state_t          r_state_q, r_state_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic              frame_ready_q, frame_ready_d;
  logic              err_short_q, err_short_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [RD_LAT-1:0] rvalid_q, rvalid_d;
  logic              r_start, r_restart, w_start, w_drop;

  always_comb begin
    // A display start claims the buffer before a same-cycle sensor start.
    r_start   = (r_state_q == R_IDLE) && OUT_VS && frame_ready_q && (w_state_q != W_CAPTURE);
    r_restart = (r_state_q == R_STREAM) && OUT_VS;
    w_start   = (w_state_q == W_IDLE) && fval_rise && (r_state_q != R_STREAM) && !r_start;
    w_drop    = (w_state_q == W_IDLE) && fval_rise && !w_start;

    W_CLR = w_start;
    W_DE  = (w_state_q == W_CAPTURE) && IN_DVAL && IN_FVAL && (wcnt_q < FP_CNT);
    R_CLR = r_start || r_restart;
    // The clear cycle owns the read counter, so no advance alongside it.
    R_DE  = (r_state_q == R_STREAM) && !r_restart && OUT_REQ && (rcnt_q < FP_CNT);

    w_state_d     = w_state_q;
    r_state_d     = r_state_q;
    wcnt_d        = wcnt_q;
    rcnt_d        = rcnt_q;
    frame_ready_d = frame_ready_q;
    err_short_d   = err_short_q;
    drop_cnt_d    = drop_cnt_q;

    case (w_state_q)
      W_IDLE: begin
        if (w_start) begin
          w_state_d     = W_CAPTURE;
          wcnt_d        = '0;
          frame_ready_d = 1'b0;
        end
      end
      W_CAPTURE: begin
        if (W_DE) wcnt_d = wcnt_q + CNT_W'(1);
        if (!IN_FVAL) begin
          w_state_d = W_IDLE;
          if (wcnt_q == FP_CNT) frame_ready_d = 1'b1;
          else                  err_short_d   = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    if (w_drop) drop_cnt_d = sat_inc8(drop_cnt_q);

    case (r_state_q)
      R_IDLE: begin
        if (r_start) begin
          r_state_d = R_STREAM;
          rcnt_d    = '0;
        end
      end
      R_STREAM: begin
        if (r_restart) begin
          rcnt_d = '0;
        end else if (R_DE) begin
          rcnt_d = rcnt_q + CNT_W'(1);
          if (rcnt_q == FP_LAST) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    rvalid_d    = rvalid_q;
    rvalid_d[0] = R_DE;
    for (int i = 1; i < RD_LAT; i++) rvalid_d[i] = rvalid_q[i-1];
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      w_state_q     <= W_IDLE;
      r_state_q     <= R_IDLE;
      wcnt_q        <= '0;
      rcnt_q        <= '0;
      frame_ready_q <= 1'b0;
      err_short_q   <= 1'b0;
      drop_cnt_q    <= 8'd0;
      rvalid_q      <= '0;
    end else begin
      w_state_q     <= w_state_d;
      r_state_q     <= r_state_d;
      wcnt_q        <= wcnt_d;
      rcnt_q        <= rcnt_d;
      frame_ready_q <= frame_ready_d;
      err_short_q   <= err_short_d;
      drop_cnt_q    <= drop_cnt_d;
      rvalid_q      <= rvalid_d;
    end
  end

  assign R_VALID     = rvalid_q[RD_LAT-1];
  assign FRAME_READY = frame_ready_q;
  assign ERR_SHORT   = err_short_q;
  assign DROP_CNT    = drop_cnt_q;

endmodule
`default_nettype wire
